// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side bus between the SRAM bridge and the interconnect: AR/R/AW/W/B channels.
// master modport is the bridge; slave modport is the memory/interconnect side.
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the core's inst/data SRAM-like ports into one AXI3 master; one read and one write outstanding,
// data requests win over instruction requests. addr_ok/data_ok/bready are combinational from registered state.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    sram_axi_bridge_if.master axi
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;

    logic        arvalid_q;
    logic        rready_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;

    logic        awvalid_q;
    logic        wvalid_q;
    logic        aw_done;
    logic        w_done;
    logic [31:0] awaddr_q;
    logic [1:0]  awsize_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic        r_idle;
    logic        w_idle;
    logic        data_rd_acc;
    logic        inst_rd_acc;
    logic        data_wr_acc;
    logic        r_beat;
    logic        r_data_beat;
    logic        b_fire;
    logic        bready_c;
    logic        aw_hs;
    logic        w_hs;

    // Idle qualifiers are gated by reset so no request is acknowledged while the bridge is being cleared.
    assign r_idle      = (r_state == R_IDLE) && !reset;
    assign w_idle      = (w_state == W_IDLE) && !reset;

    // Data reads wait for the write side to drain so a read never overtakes an earlier store.
    assign data_rd_acc = r_idle && data_sram_req && !data_sram_wr && (w_state == W_IDLE);
    assign inst_rd_acc = r_idle && inst_sram_req && !data_rd_acc;
    assign data_wr_acc = w_idle && data_sram_req && data_sram_wr && !data_rd_acc;

    assign r_beat      = rready_q && axi.rvalid;
    assign r_data_beat = r_beat && (axi.rid == DATA_ID);
    // B is stalled for a cycle when a data R beat lands, keeping each data_ok pulse a single event.
    assign bready_c    = (w_state == W_B) && !r_data_beat;
    assign b_fire      = axi.bvalid && bready_c;
    assign aw_hs       = awvalid_q && axi.awready;
    assign w_hs        = wvalid_q && axi.wready;

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = r_beat && (axi.rid == INST_ID);
    assign data_sram_data_ok = r_data_beat || b_fire;
    assign inst_sram_rdata   = axi.rdata;
    assign data_sram_rdata   = axi.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            arid_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arsize_q  <= 2'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (data_rd_acc) begin
                        arid_q    <= DATA_ID;
                        araddr_q  <= data_sram_addr;
                        arsize_q  <= data_sram_size;
                        arvalid_q <= 1'b1;
                        r_state   <= R_AR;
                    end else if (inst_rd_acc) begin
                        arid_q    <= INST_ID;
                        araddr_q  <= inst_sram_addr;
                        arsize_q  <= inst_sram_size;
                        arvalid_q <= 1'b1;
                        r_state   <= R_AR;
                    end
                end
                R_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        r_state   <= R_R;
                    end
                end
                R_R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    r_state   <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awaddr_q  <= 32'd0;
            awsize_q  <= 2'd0;
            wstrb_q   <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_acc) begin
                        awaddr_q  <= data_sram_addr;
                        awsize_q  <= data_sram_size;
                        wstrb_q   <= data_sram_wstrb;
                        wdata_q   <= data_sram_wdata;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        w_state   <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (b_fire) begin
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    w_state   <= W_IDLE;
                end
            endcase
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, arsize_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, awsize_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'd0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;

    assign axi.wid     = DATA_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_c;

    // Inputs the core or fabric drive but this bridge has no use for.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                         axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sram_axi_bridge_if axi();

    sram_axi_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_req),
        .inst_sram_wr      (inst_wr),
        .inst_sram_size    (inst_size),
        .inst_sram_wstrb   (inst_wstrb),
        .inst_sram_addr    (inst_addr),
        .inst_sram_wdata   (inst_wdata),
        .inst_sram_addr_ok (inst_addr_ok),
        .inst_sram_data_ok (inst_data_ok),
        .inst_sram_rdata   (inst_rdata),
        .data_sram_req     (data_req),
        .data_sram_wr      (data_wr),
        .data_sram_size    (data_size),
        .data_sram_wstrb   (data_wstrb),
        .data_sram_addr    (data_addr),
        .data_sram_wdata   (data_wdata),
        .data_sram_addr_ok (data_addr_ok),
        .data_sram_data_ok (data_data_ok),
        .data_sram_rdata   (data_rdata),
        .axi               (axi.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = 0; data_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bid = 4'd1; axi.bresp = 0; axi.bvalid = 0;
        next_cyc(); next_cyc();
        reset = 1'b0;
        smp();
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid",  axi.wvalid,  0);
        check("rst_bready",  axi.bready,  0);
        check("rst_rready",  axi.rready,  0);

        // 1: instruction fetch, zero-wait AR and R
        next_cyc();
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
        smp();
        check("t1_inst_addr_ok", inst_addr_ok, 1);
        check("t1_arvalid_T",    axi.arvalid, 0);
        next_cyc();
        inst_req = 0; axi.arready = 1;
        smp();
        check("t1_arvalid",  axi.arvalid, 1);
        check("t1_arid",     axi.arid, 0);
        check("t1_araddr",   axi.araddr, 32'hBFC0_0000);
        check("t1_arsize",   axi.arsize, 2);
        check("t1_arlen",    axi.arlen, 0);
        check("t1_arburst",  axi.arburst, 1);
        next_cyc();
        axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h3C08_BFAF;
        smp();
        check("t1_rready",       axi.rready, 1);
        check("t1_inst_data_ok", inst_data_ok, 1);
        check("t1_data_data_ok", data_data_ok, 0);
        check("t1_inst_rdata",   inst_rdata, 32'h3C08_BFAF);
        next_cyc();
        axi.rvalid = 0;
        smp();
        check("t1_rready_drop",  axi.rready, 0);
        check("t1_data_ok_drop", inst_data_ok, 0);

        // 2: simultaneous inst and data reads, data first
        next_cyc();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_wr = 0; data_addr = 32'h200; data_size = 2'd2;
        smp();
        check("t2_data_addr_ok", data_addr_ok, 1);
        check("t2_inst_addr_ok", inst_addr_ok, 0);
        next_cyc();
        data_req = 0; axi.arready = 1;
        smp();
        check("t2_arid_data",    axi.arid, 1);
        check("t2_araddr_data",  axi.araddr, 32'h200);
        check("t2_inst_busy",    inst_addr_ok, 0);
        next_cyc();
        axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h1111_2222;
        smp();
        check("t2_data_data_ok", data_data_ok, 1);
        check("t2_inst_data_ok", inst_data_ok, 0);
        check("t2_data_rdata",   data_rdata, 32'h1111_2222);
        check("t2_inst_wait",    inst_addr_ok, 0);
        next_cyc();
        axi.rvalid = 0;
        smp();
        check("t2_inst_addr_ok_late", inst_addr_ok, 1);
        next_cyc();
        inst_req = 0; axi.arready = 1;
        smp();
        check("t2_arid_inst",   axi.arid, 0);
        check("t2_araddr_inst", axi.araddr, 32'h100);
        next_cyc();
        axi.arready = 0; axi.rvalid = 1; axi.rid = 4'd0;
        smp();
        check("t2_inst_data_ok", inst_data_ok, 1);
        next_cyc();
        axi.rvalid = 0;

        // 3: halfword write, AW accepted before W
        data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h1000;
        data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        smp();
        check("t3_data_addr_ok", data_addr_ok, 1);
        next_cyc();
        data_req = 0; axi.awready = 1;
        smp();
        check("t3_awvalid", axi.awvalid, 1);
        check("t3_wvalid",  axi.wvalid, 1);
        check("t3_awaddr",  axi.awaddr, 32'h1000);
        check("t3_awsize",  axi.awsize, 1);
        check("t3_awid",    axi.awid, 1);
        check("t3_wid",     axi.wid, 1);
        check("t3_wstrb",   axi.wstrb, 4'b0011);
        check("t3_wdata",   axi.wdata, 32'hDEAD_BEEF);
        check("t3_wlast",   axi.wlast, 1);
        next_cyc();
        axi.awready = 0;
        smp();
        check("t3_awvalid_drop", axi.awvalid, 0);
        check("t3_wvalid_hold",  axi.wvalid, 1);
        check("t3_bready_early", axi.bready, 0);
        next_cyc();
        axi.wready = 1;
        smp();
        check("t3_wvalid_T3", axi.wvalid, 1);
        next_cyc();
        axi.wready = 0;
        smp();
        check("t3_wvalid_drop", axi.wvalid, 0);
        check("t3_bready",      axi.bready, 1);
        check("t3_no_ok",       data_data_ok, 0);
        next_cyc();
        axi.bvalid = 1;
        smp();
        check("t3_b_data_ok", data_data_ok, 1);
        next_cyc();
        axi.bvalid = 0;
        smp();
        check("t3_bready_done", axi.bready, 0);
        check("t3_ok_once",     data_data_ok, 0);

        // 4: data read held off until the write has fully completed
        next_cyc();
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h2000; data_wstrb = 4'hf;
        smp();
        check("t4_wr_addr_ok", data_addr_ok, 1);
        next_cyc();
        data_wr = 0; data_addr = 32'h3000; axi.awready = 1; axi.wready = 1;
        smp();
        check("t4_rd_blocked_req", data_addr_ok, 0);
        next_cyc();
        axi.awready = 0; axi.wready = 0;
        smp();
        check("t4_rd_blocked_b", data_addr_ok, 0);
        check("t4_bready",       axi.bready, 1);
        next_cyc();
        axi.bvalid = 1;
        smp();
        check("t4_rd_blocked_hs", data_addr_ok, 0);
        check("t4_b_ok",          data_data_ok, 1);
        next_cyc();
        axi.bvalid = 0;
        smp();
        check("t4_rd_accept", data_addr_ok, 1);
        next_cyc();
        data_req = 0; axi.arready = 1;
        smp();
        check("t4_araddr", axi.araddr, 32'h3000);
        check("t4_arid",   axi.arid, 1);
        next_cyc();
        axi.arready = 0;

        // 5: data R beat and B response in the same cycle (read is sitting in R_R)
        data_req = 1; data_wr = 1; data_addr = 32'h4000;
        smp();
        check("t5_wr_addr_ok", data_addr_ok, 1);
        check("t5_rready",     axi.rready, 1);
        next_cyc();
        data_req = 0; axi.awready = 1; axi.wready = 1;
        smp();
        check("t5_awvalid", axi.awvalid, 1);
        next_cyc();
        axi.awready = 0; axi.wready = 0;
        axi.rvalid = 1; axi.rid = 4'd1; axi.rdata = 32'h55AA_55AA; axi.bvalid = 1;
        smp();
        check("t5_bready_stall", axi.bready, 0);
        check("t5_ok_first",     data_data_ok, 1);
        check("t5_rdata",        data_rdata, 32'h55AA_55AA);
        next_cyc();
        axi.rvalid = 0;
        smp();
        check("t5_bready", axi.bready, 1);
        check("t5_ok_second", data_data_ok, 1);
        next_cyc();
        axi.bvalid = 0;
        smp();
        check("t5_ok_end", data_data_ok, 0);

        // 6: reset while AR is pending
        next_cyc();
        inst_req = 1; inst_addr = 32'h500;
        smp();
        check("t6_addr_ok", inst_addr_ok, 1);
        next_cyc();
        inst_req = 0;
        smp();
        check("t6_arvalid", axi.arvalid, 1);
        next_cyc();
        reset = 1;
        smp();
        next_cyc();
        reset = 0; axi.rvalid = 1; axi.rid = 4'd0; inst_req = 1; inst_addr = 32'h600;
        smp();
        check("t6_arvalid_rst", axi.arvalid, 0);
        check("t6_rready_rst",  axi.rready, 0);
        check("t6_no_data_ok",  inst_data_ok, 0);
        check("t6_idle",        inst_addr_ok, 1);
        next_cyc();
        axi.rvalid = 0; inst_req = 0;
        next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
